// File: rtl/exc_sequencer.sv
// Feeds CP0 its exception inputs from the M stage and sequences exception entry and ERET return.
// Emits flush, redirect and front-end hold, with a RECOVER_CYCLES-long stall after each redirect.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_PC     = 32'h0000_4180,
  parameter int          RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [4:0]  m_excode,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_eret,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  cp0_excode_o,
  output logic [31:0] cp0_vpc_o,
  output logic        cp0_bd_o,
  output logic        exl_clr,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        front_stall,
  output logic        busy
);

  typedef enum logic [1:0] {RUN, EXC_REDIRECT, ERET_REDIRECT, RECOVER} state_t;

  localparam logic [3:0] LP_REC_INIT = 4'(RECOVER_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_resume_pc, w_resume_pc_nxt;
  logic [3:0]  r_rec_cnt, w_rec_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_resume_pc <= 32'd0;
      r_rec_cnt   <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_resume_pc <= w_resume_pc_nxt;
      r_rec_cnt   <= w_rec_cnt_nxt;
    end
  end

  // CP0 has already committed EPC/EXL when it raises req, so req preempts every state.
  always_comb begin
    w_state_nxt     = r_state;
    w_resume_pc_nxt = r_resume_pc;
    w_rec_cnt_nxt   = r_rec_cnt;
    if (cp0_req) begin
      w_state_nxt     = EXC_REDIRECT;
      w_resume_pc_nxt = HANDLER_PC;
    end else begin
      case (r_state)
        RUN: begin
          if (m_valid && m_eret) begin
            w_state_nxt     = ERET_REDIRECT;
            w_resume_pc_nxt = cp0_epc;
          end
        end
        EXC_REDIRECT, ERET_REDIRECT: begin
          w_state_nxt   = RECOVER;
          w_rec_cnt_nxt = LP_REC_INIT;
        end
        RECOVER: begin
          if (r_rec_cnt == 4'd0) w_state_nxt = RUN;
          else                   w_rec_cnt_nxt = r_rec_cnt - 4'd1;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // Outside RUN, M holds a bubble; a late interrupt must save resume_pc as its restart PC.
  always_comb begin
    cp0_excode_o = 5'd0;
    cp0_vpc_o    = r_resume_pc;
    cp0_bd_o     = 1'b0;
    exl_clr      = 1'b0;
    flush        = 1'b0;
    redirect     = 1'b0;
    front_stall  = 1'b0;
    redirect_pc  = r_resume_pc;
    busy         = (r_state != RUN);
    case (r_state)
      RUN: begin
        cp0_excode_o = m_valid ? m_excode : 5'd0;
        cp0_vpc_o    = m_pc;
        cp0_bd_o     = m_valid & m_bd;
      end
      EXC_REDIRECT: begin
        flush    = 1'b1;
        redirect = 1'b1;
      end
      ERET_REDIRECT: begin
        flush    = 1'b1;
        redirect = 1'b1;
        exl_clr  = 1'b1;
      end
      RECOVER: front_stall = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboarded random and directed bench for exc_sequencer at RECOVER_CYCLES of 2 and 1.
module tb_exc_sequencer;

  localparam logic [31:0] HPC = 32'h0000_4180;

  typedef struct packed {
    logic        busy;
    logic        flush;
    logic        redirect;
    logic        exl_clr;
    logic        front_stall;
    logic        bd;
    logic [4:0]  excode;
    logic [31:0] rpc;
    logic [31:0] vpc;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_valid = 1'b0;
  logic [4:0]  m_excode = 5'd0;
  logic [31:0] m_pc = 32'd0;
  logic        m_bd = 1'b0;
  logic        m_eret = 1'b0;
  logic        cp0_req = 1'b0;
  logic [31:0] cp0_epc = 32'd0;

  logic [4:0]  exc_a, exc_b;
  logic [31:0] vpc_a, vpc_b, rpc_a, rpc_b;
  logic        bd_a, bd_b, exl_a, exl_b, fl_a, fl_b, rd_a, rd_b, st_a, st_b, bz_a, bz_b;

  always #5 clk = ~clk;

  exc_sequencer #(.HANDLER_PC(HPC), .RECOVER_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_excode(m_excode), .m_pc(m_pc),
    .m_bd(m_bd), .m_eret(m_eret), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
    .cp0_excode_o(exc_a), .cp0_vpc_o(vpc_a), .cp0_bd_o(bd_a), .exl_clr(exl_a),
    .flush(fl_a), .redirect(rd_a), .redirect_pc(rpc_a), .front_stall(st_a), .busy(bz_a));

  exc_sequencer #(.HANDLER_PC(HPC), .RECOVER_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_excode(m_excode), .m_pc(m_pc),
    .m_bd(m_bd), .m_eret(m_eret), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
    .cp0_excode_o(exc_b), .cp0_vpc_o(vpc_b), .cp0_bd_o(bd_b), .exl_clr(exl_b),
    .flush(fl_b), .redirect(rd_b), .redirect_pc(rpc_b), .front_stall(st_b), .busy(bz_b));

  out_t act_a, act_b;
  assign act_a = '{bz_a, fl_a, rd_a, exl_a, st_a, bd_a, exc_a, rpc_a, vpc_a};
  assign act_b = '{bz_b, fl_b, rd_b, exl_b, st_b, bd_b, exc_b, rpc_b, vpc_b};

  // Reference: a pending redirect (with target and kind) followed by a count of stall cycles.
  int          rc[2] = '{2, 1};
  bit          pend[2];
  bit          is_eret[2];
  logic [31:0] tgt[2];
  int          stall_left[2];

  out_t q_a[$];
  out_t q_b[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  function automatic void model_edge(int k);
    if (reset) begin
      pend[k] = 0; is_eret[k] = 0; tgt[k] = 32'd0; stall_left[k] = 0;
    end else if (cp0_req) begin
      pend[k] = 1; is_eret[k] = 0; tgt[k] = HPC; stall_left[k] = 0;
    end else if (pend[k]) begin
      pend[k] = 0; stall_left[k] = rc[k];
    end else if (stall_left[k] > 0) begin
      stall_left[k] = stall_left[k] - 1;
    end else if (m_valid && m_eret) begin
      pend[k] = 1; is_eret[k] = 1; tgt[k] = cp0_epc;
    end
  endfunction

  function automatic out_t expect_out(int k);
    out_t e;
    bit   bsy;
    bsy           = pend[k] || (stall_left[k] > 0);
    e.busy        = bsy;
    e.flush       = pend[k];
    e.redirect    = pend[k];
    e.exl_clr     = pend[k] && is_eret[k];
    e.front_stall = stall_left[k] > 0;
    e.bd          = !bsy && m_valid && m_bd;
    e.excode      = (!bsy && m_valid) ? m_excode : 5'd0;
    e.rpc         = tgt[k];
    e.vpc         = bsy ? tgt[k] : m_pc;
    return e;
  endfunction

  task automatic step(input bit rst, input bit v, input logic [4:0] exc, input logic [31:0] pc,
                      input bit bd, input bit eret, input bit req, input logic [31:0] epc);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    reset = rst; m_valid = v; m_excode = exc; m_pc = pc; m_bd = bd;
    m_eret = eret; cp0_req = req; cp0_epc = epc;
    q_a.push_back(expect_out(0));
    q_b.push_back(expect_out(1));
  endtask

  // Bubble in M: junk on excode/eret/bd must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 5'($urandom), $urandom, 1'($urandom), 1'($urandom), 0, $urandom);
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        compared++;
        if (act_a !== e) begin
          mismatched++;
          $display("FAIL outs_rc2 cyc=%0d got=%h expected=%h", cyc, act_a, e);
        end
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        compared++;
        if (act_b !== e) begin
          mismatched++;
          $display("FAIL outs_rc1 cyc=%0d got=%h expected=%h", cyc, act_b, e);
        end
      end
    end
  end

  initial begin : driver
    step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    idle(10);
    // exception with BD set
    step(0, 1, 5'd12, 32'h3010, 1, 0, 1, 32'h0);
    idle(4);
    // plain ERET
    step(0, 1, 5'd0, 32'h2000, 0, 1, 0, 32'h3014);
    idle(4);
    // ERET colliding with req
    step(0, 1, 5'd0, 32'h2000, 0, 1, 1, 32'h3014);
    idle(4);
    // interrupt in first RECOVER cycle after ERET
    step(0, 1, 5'd0, 32'h2000, 0, 1, 0, 32'h3014);
    idle(1);
    step(0, 0, 5'd0, 32'h0, 0, 0, 1, 32'h0);
    idle(5);
    // reset during RECOVER
    step(0, 1, 5'd4, 32'h3100, 0, 0, 1, 32'h0);
    idle(1);
    step(1, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0,
           {$urandom_range(0, 32'h0000_ffff), 2'b00},
           1'($urandom),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 11) == 0),
           {$urandom_range(0, 32'h0000_ffff), 2'b00});
    end
    repeat (3) @(negedge clk);
    #1;
    if (q_a.size() + q_b.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d expected=0", q_a.size() + q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Pipeline-side controller for the CP0 coprocessor.
- Drives CP0's exception inputs from the M stage and sequences exception entry and ERET return.
- Issues pipeline flush, PC redirect and front-end hold.
- Sits between the M-stage pipeline register, CP0 and the F-stage PC mux.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address.
- RECOVER_CYCLES, 2, cycles front end is held after a redirect (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- m_valid  in  1  M stage holds a real (non-bubble) instruction.
- m_excode  in  5  M-stage exception code, 0 = none.
- m_pc  in  32  M-stage instruction PC.
- m_bd  in  1  M-stage instruction is in a branch delay slot.
- m_eret  in  1  M-stage instruction is ERET.
- cp0_req  in  1  CP0 Req: exception or interrupt is being taken this cycle.
- cp0_epc  in  32  CP0 EPC register value.
- cp0_excode_o  out  5  ExcCode to CP0.
- cp0_vpc_o  out  32  victim PC to CP0.
- cp0_bd_o  out  1  BD flag to CP0.
- exl_clr  out  1  EXL clear to CP0.
- flush  out  1  kill F/D/E/M instructions.
- redirect  out  1  load PC from redirect_pc.
- redirect_pc  out  32  next fetch address.
- front_stall  out  1  hold F/D.
- busy  out  1  state != RUN.

Behaviour:
- States: RUN, EXC_REDIRECT, ERET_REDIRECT, RECOVER.
- Registers: state, resume_pc[31:0], rec_cnt[3:0].
- Reset: state=RUN, resume_pc=0, rec_cnt=0. All outputs then read 0, except cp0_vpc_o, which equals m_pc.

CP0 drive (combinational):
- In RUN:
  - cp0_excode_o = m_valid ? m_excode : 0
  - cp0_vpc_o = m_pc
  - cp0_bd_o = m_valid & m_bd
- In any other state: cp0_excode_o=0, cp0_bd_o=0, cp0_vpc_o=resume_pc. This makes a late interrupt save the correct restart PC, since M holds a bubble.

Transitions (evaluated at posedge, priority top-down):
- Any state, cp0_req=1 → EXC_REDIRECT; resume_pc <= HANDLER_PC. CP0 has already committed EPC/EXL at the same edge, so this must always be honoured, including during ERET_REDIRECT and RECOVER.
- RUN, m_valid & m_eret & !cp0_req → ERET_REDIRECT; resume_pc <= cp0_epc.
- EXC_REDIRECT or ERET_REDIRECT, no req → RECOVER; rec_cnt <= RECOVER_CYCLES-1.
- RECOVER, rec_cnt==0 → RUN; else rec_cnt decrements.

Outputs per state:
- EXC_REDIRECT: flush=1, redirect=1, redirect_pc=resume_pc, front_stall=0, exl_clr=0.
- ERET_REDIRECT: flush=1, redirect=1, redirect_pc=resume_pc, exl_clr=1 (exactly one cycle).
- RECOVER: front_stall=1, flush=0, redirect=0.
- RUN: all of flush/redirect/exl_clr/front_stall = 0.
- redirect_pc = resume_pc whenever redirect=1; otherwise don't-care, driven as resume_pc.
- busy = (state != RUN).

Latency:
- Exception or ERET in M at cycle N → flush+redirect at N+1 → stall N+2..N+1+RECOVER_CYCLES → RUN.

Boundary conditions:
- ERET and cp0_req in the same cycle: exception wins, ERET is dropped, exl_clr is not asserted.
- Interrupt arriving in RECOVER after ERET: new EXC_REDIRECT; cp0_vpc_o = ERET target (EPC value).
- m_valid=0 with nonzero m_excode or m_eret: ignored.
- Reset asserted mid-sequence: RUN at the next edge; no flush or exl_clr pulse is emitted.
- RECOVER_CYCLES=1: RECOVER lasts exactly one cycle.

Test Plan:
- Reset, then idle with m_valid=0 → busy=0, flush=0, cp0_excode_o=0, exl_clr=0 for 10 cycles.
- Exception: m_valid=1, m_excode=5'd12, m_pc=32'h3010, m_bd=1; CP0 responds cp0_req=1 → same cycle cp0_excode_o=12, cp0_vpc_o=32'h3010, cp0_bd_o=1; next cycle flush=1, redirect=1, redirect_pc=32'h4180; then front_stall=1 for 2 cycles; then busy=0.
- ERET: cp0_epc=32'h3014, m_eret=1, cp0_req=0 → next cycle redirect_pc=32'h3014, flush=1, exl_clr=1 for exactly one cycle; then 2 stall cycles.
- ERET and cp0_req=1 in the same cycle → redirect_pc=32'h4180, exl_clr never asserted.
- After ERET to 32'h3014, cp0_req=1 in the first RECOVER cycle → cp0_vpc_o=32'h3014, cp0_excode_o=0; next cycle redirect_pc=32'h4180; stall count restarts at 2.
- Reset asserted during RECOVER → next cycle busy=0, front_stall=0, no redirect pulse.
